// File: rtl/vram_pkg.sv
// Shared constants and types for the text VRAM arbiter slice.
package vram_pkg;

    localparam int unsigned ROW_W  = 5;
    localparam int unsigned COL_W  = 7;
    localparam int unsigned CHAR_W = 8;

    localparam int unsigned COLS = 100;
    localparam int unsigned ROWS = 30;

    localparam logic [CHAR_W-1:0] FILL_CHAR = 8'h20;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/vram_clear_seq.sv
// Row-clear sequencer: walks one text row writing the fill character,
// advancing only in cycles where the display fetch leaves the RAM free.
module vram_clear_seq
    import vram_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_start,
    input  logic [ROW_W-1:0] clr_row,
    input  logic             grant,
    output logic             busy,
    output logic             wr_req,
    output logic [ROW_W-1:0] wr_row,
    output logic [COL_W-1:0] wr_col
);

    clr_state_t       state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             last_col;

    assign last_col = (col_q == COL_W'(COLS - 1));

    // State, latched row and column counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLR_IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Next state: an out-of-range row still walks all columns so the
    // clear takes the same time, it just never raises a write request.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        unique case (state_q)
            CLR_IDLE: begin
                if (clr_start) begin
                    state_d = CLR_CLEAR;
                    row_d   = clr_row;
                    col_d   = '0;
                end
            end
            CLR_CLEAR: begin
                if (grant) begin
                    if (last_col) begin
                        state_d = CLR_IDLE;
                        col_d   = '0;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    assign busy   = (state_q == CLR_CLEAR);
    assign wr_req = busy && (row_q < ROW_W'(ROWS));
    assign wr_row = row_q;
    assign wr_col = col_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port text VRAM arbiter: display fetch > row clear > terminal port.
module vram_arbiter
    import vram_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_ce,
    input  logic [ROW_W-1:0]  disp_row,
    input  logic [COL_W-1:0]  disp_col,
    output logic [CHAR_W-1:0] disp_char,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ROW_W-1:0]  req_row,
    input  logic [COL_W-1:0]  req_col,
    input  logic [CHAR_W-1:0] req_data,
    output logic              rsp_valid,
    output logic [CHAR_W-1:0] rsp_data,
    input  logic              clr_start,
    input  logic [ROW_W-1:0]  clr_row,
    output logic              clr_busy,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ROW_W-1:0]  ram_row,
    output logic [COL_W-1:0]  ram_col,
    output logic [CHAR_W-1:0] ram_wdata,
    input  logic [CHAR_W-1:0] ram_rdata
);

    logic              clr_wr_req;
    logic [ROW_W-1:0]  clr_wr_row;
    logic [COL_W-1:0]  clr_wr_col;
    logic              clr_fire;
    logic              req_fire;
    logic              req_in_range;
    logic              rsp_pend_q;
    logic              rsp_oor_q;
    logic              disp_pend_q;
    logic [CHAR_W-1:0] disp_cap_q;

    vram_clear_seq u_clear (
        .clk       (clk),
        .reset     (reset),
        .clr_start (clr_start),
        .clr_row   (clr_row),
        .grant     (!disp_ce),
        .busy      (clr_busy),
        .wr_req    (clr_wr_req),
        .wr_row    (clr_wr_row),
        .wr_col    (clr_wr_col)
    );

    assign req_in_range = (req_row < ROW_W'(ROWS)) && (req_col < COL_W'(COLS));
    assign req_ready    = !reset && !disp_ce && !clr_busy && !clr_start;
    assign req_fire     = req_valid && req_ready;
    // The sequencer may still read CLEAR during the reset cycle; keep it off the bus.
    assign clr_fire     = clr_wr_req && !disp_ce && !reset;

    // RAM port mux: display always wins, then the clear, then the terminal.
    always_comb begin
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_row   = '0;
        ram_col   = '0;
        ram_wdata = '0;
        if (disp_ce) begin
            ram_ce  = 1'b1;
            ram_row = disp_row;
            ram_col = disp_col;
        end else if (clr_fire) begin
            ram_ce    = 1'b1;
            ram_we    = 1'b1;
            ram_row   = clr_wr_row;
            ram_col   = clr_wr_col;
            ram_wdata = FILL_CHAR;
        end else if (req_fire && req_in_range) begin
            ram_ce    = 1'b1;
            ram_we    = req_write;
            ram_row   = req_row;
            ram_col   = req_col;
            ram_wdata = req_data;
        end
    end

    // Track outstanding read responses and the display capture register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_pend_q  <= 1'b0;
            rsp_oor_q   <= 1'b0;
            disp_pend_q <= 1'b0;
            disp_cap_q  <= '0;
        end else begin
            rsp_pend_q  <= req_fire && !req_write;
            rsp_oor_q   <= !req_in_range;
            disp_pend_q <= disp_ce;
            if (disp_pend_q) begin
                disp_cap_q <= ram_rdata;
            end
        end
    end

    assign rsp_valid = rsp_pend_q;
    assign rsp_data  = !rsp_pend_q ? '0 : (rsp_oor_q ? FILL_CHAR : ram_rdata);
    assign disp_char = disp_pend_q ? ram_rdata : disp_cap_q;

endmodule
